vga_timing_sequencer: RTL and testbench

Sequences the horizontal and vertical scan counters of the VGA controller. It walks each axis through sync, back-porch, active and front-porch phases, and generates Hsync/Vsync, the video-active window and pixel coordinates. It switches between a built-in resolution table only at frame boundaries, using a request/acknowledge handshake. It sits between the colour-pattern generator, which consumes coordinates, and the VGA output pins.

---
 rtl/vga_timing_sequencer.sv | 143 ++++++++++++++
 tb/tb_vga_timing_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/vga_timing_sequencer.sv
// rtl/vga_timing_sequencer.sv - VGA scan counters, sync/active decode and frame-boundary mode switch
module vga_timing_sequencer #(
  parameter int REZ_MAX_WIDTH = 12,
  parameter int PULSE_WIDTH   = 8
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Mode_sel,
  input  logic                     Mode_req,
  output logic                     Mode_ack,
  output logic                     Hsync,
  output logic                     Vsync,
  output logic                     Video_on,
  output logic [REZ_MAX_WIDTH-1:0] Pixel_x,
  output logic [REZ_MAX_WIDTH-1:0] Pixel_y,
  output logic                     Line_start,
  output logic                     Frame_start
);

  localparam int W = REZ_MAX_WIDTH;

  typedef enum logic [1:0] {
    PH_SYNC,
    PH_BACK_PORCH,
    PH_ACTIVE,
    PH_FRONT_PORCH
  } phase_t;

  logic [W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic         mode_q, mode_d;
  logic         pend_q, pend_d;
  logic         pend_sel_q, pend_sel_d;
  logic         switched_q, switched_d;
  logic         ack_q, ack_d;
  logic         hsync_q, hsync_d, vsync_q, vsync_d;
  logic         video_on_q, video_on_d;
  logic [W-1:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic         line_start_q, line_start_d, frame_start_q, frame_start_d;

  logic [PULSE_WIDTH-1:0] hs_len, hb_len, vs_len, vb_len;
  logic [W-1:0]           ha_len, h_total, va_len, v_total;
  logic [W-1:0]           h_act_start, h_act_end, v_act_start, v_act_end;
  logic                   h_last, v_last, frame_end, apply, req_ok;
  phase_t                 h_phase, v_phase;

  function automatic phase_t phase_of(input logic [W-1:0] cnt, input logic [W-1:0] s_end,
                                      input logic [W-1:0] a_start, input logic [W-1:0] a_end);
    if (cnt < s_end)        return PH_SYNC;
    else if (cnt < a_start) return PH_BACK_PORCH;
    else if (cnt < a_end)   return PH_ACTIVE;
    else                    return PH_FRONT_PORCH;
  endfunction

  always_comb begin
    if (mode_q) begin
      hs_len = PULSE_WIDTH'(2);  hb_len = PULSE_WIDTH'(2);  ha_len = W'(8);   h_total = W'(14);
      vs_len = PULSE_WIDTH'(1);  vb_len = PULSE_WIDTH'(1);  va_len = W'(4);   v_total = W'(7);
    end else begin
      hs_len = PULSE_WIDTH'(96); hb_len = PULSE_WIDTH'(48); ha_len = W'(640); h_total = W'(800);
      vs_len = PULSE_WIDTH'(2);  vb_len = PULSE_WIDTH'(33); va_len = W'(480); v_total = W'(525);
    end
  end

  always_comb begin
    h_act_start = W'(hs_len) + W'(hb_len);
    h_act_end   = h_act_start + ha_len;
    v_act_start = W'(vs_len) + W'(vb_len);
    v_act_end   = v_act_start + va_len;
    h_phase     = phase_of(h_cnt_q, W'(hs_len), h_act_start, h_act_end);
    v_phase     = phase_of(v_cnt_q, W'(vs_len), v_act_start, v_act_end);

    h_last    = (h_cnt_q == h_total - W'(1));
    v_last    = (v_cnt_q == v_total - W'(1));
    frame_end = h_last && v_last;
    apply     = frame_end && pend_q;

    h_cnt_d = h_last ? '0 : h_cnt_q + W'(1);
    v_cnt_d = v_cnt_q;
    if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + W'(1);

    // Requests are ignored from the boundary until the ack has been visible for one cycle
    req_ok     = Mode_req && !switched_q && !ack_q;
    mode_d     = apply ? pend_sel_q : mode_q;
    switched_d = apply;
    pend_sel_d = req_ok ? Mode_sel : pend_sel_q;
    pend_d     = pend_q;
    if (apply)       pend_d = 1'b0;
    else if (req_ok) pend_d = 1'b1;

    hsync_d       = (h_phase != PH_SYNC);
    vsync_d       = (v_phase != PH_SYNC);
    video_on_d    = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    pixel_x_d     = video_on_d ? h_cnt_q - h_act_start : '0;
    pixel_y_d     = video_on_d ? v_cnt_q - v_act_start : '0;
    line_start_d  = (h_cnt_q == '0);
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    ack_d         = switched_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      mode_q        <= 1'b0;
      pend_q        <= 1'b0;
      pend_sel_q    <= 1'b0;
      switched_q    <= 1'b0;
      ack_q         <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      mode_q        <= mode_d;
      pend_q        <= pend_d;
      pend_sel_q    <= pend_sel_d;
      switched_q    <= switched_d;
      ack_q         <= ack_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign Mode_ack    = ack_q;
  assign Hsync       = hsync_q;
  assign Vsync       = vsync_q;
  assign Video_on    = video_on_q;
  assign Pixel_x     = pixel_x_q;
  assign Pixel_y     = pixel_y_q;
  assign Line_start  = line_start_q;
  assign Frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_sequencer.sv
// tb/tb_vga_timing_sequencer.sv - directed checks of VGA timing and mode handshake
module tb_vga_timing_sequencer;

  localparam int W = 12;

  logic         Clk = 1'b0;
  logic         Rst, Mode_sel, Mode_req;
  logic         Mode_ack, Hsync, Vsync, Video_on, Line_start, Frame_start;
  logic [W-1:0] Pixel_x, Pixel_y;

  int total = 0;
  int bad   = 0;
  int cyc;

  vga_timing_sequencer #(.REZ_MAX_WIDTH(W), .PULSE_WIDTH(8)) dut (
    .Clk(Clk), .Rst(Rst), .Mode_sel(Mode_sel), .Mode_req(Mode_req), .Mode_ack(Mode_ack),
    .Hsync(Hsync), .Vsync(Vsync), .Video_on(Video_on), .Pixel_x(Pixel_x), .Pixel_y(Pixel_y),
    .Line_start(Line_start), .Frame_start(Frame_start)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  // {ack, hsync, vsync, video_on, line_start, frame_start, pixel_x, pixel_y}
  function automatic logic [31:0] pack(input logic ack, input logic hs, input logic vs, input logic vid,
                                       input logic ls, input logic fs, input int px, input int py);
    return {2'b00, ack, hs, vs, vid, ls, fs, W'(px), W'(py)};
  endfunction

  function automatic logic [31:0] obs();
    return {2'b00, Mode_ack, Hsync, Vsync, Video_on, Line_start, Frame_start, Pixel_x, Pixel_y};
  endfunction

  // One mode-1 frame (14x7 clocks) starting at output count 0; req_mode selects requester activity
  task automatic run_m1(input int n, input logic exp_ack, input int req_mode);
    for (int k = 0; k < n; k++) begin
      int  hc, vc, px, py;
      logic act;
      hc  = k % 14;
      vc  = k / 14;
      act = (hc >= 4) && (hc < 12) && (vc >= 2) && (vc < 6);
      px  = act ? hc - 4 : 0;
      py  = act ? vc - 2 : 0;
      chk("m1_frame", obs(), pack((k == 0) && exp_ack, hc >= 2, vc >= 1, act, hc == 0, k == 0, px, py));
      if (k == 0) Mode_req = 1'b0;
      case (req_mode)
        1: begin
          if (k == 5) begin Mode_req = 1'b1; Mode_sel = 1'b1; end
          if (k == 6) begin Mode_req = 1'b0; Mode_sel = 1'b0; end
        end
        2: if (k == 3) begin Mode_req = 1'b1; Mode_sel = 1'b1; end
        3: begin
          if (k == 20) begin Mode_req = 1'b1; Mode_sel = 1'b0; end
          if (k == 21) Mode_req = 1'b0;
        end
        default: ;
      endcase
      tick();
    end
  endtask

  initial begin
    int hs_low, hs_bad, vs_low, vs_bad, ls_cnt, ls_bad, fs_cnt, vid_cnt, first_vid, ack_cnt;
    logic [31:0] rst_v;
    rst_v = pack(0, 1, 1, 0, 0, 0, 0, 0);
    cyc = 0;
    Rst = 1'b1; Mode_req = 1'b0; Mode_sel = 1'b0;
    repeat (3) tick();
    chk("reset_hold", obs(), rst_v);

    Rst = 1'b0;
    tick();
    cyc = 0;
    chk("first_edge", obs(), pack(0, 0, 0, 0, 1, 1, 0, 0));

    hs_low = 0; hs_bad = 0; vs_low = 0; vs_bad = 0; ls_cnt = 0; ls_bad = 0;
    fs_cnt = 0; vid_cnt = 0; first_vid = -1; ack_cnt = 0;
    while (cyc < 420000) begin
      if (!Hsync) begin hs_low++; if (cyc % 800 >= 96) hs_bad++; end
      if (!Vsync) begin vs_low++; if (cyc >= 1600) vs_bad++; end
      if (Line_start) begin ls_cnt++; if (cyc % 800 != 0) ls_bad++; end
      if (Frame_start) fs_cnt++;
      if (Video_on) begin vid_cnt++; if (first_vid < 0) first_vid = cyc; end
      if (Mode_ack) ack_cnt++;
      if (cyc == 28144) chk("m0_first_pixel", {Pixel_x, Pixel_y}, {12'd0, 12'd0});
      if (cyc == 411983) chk("m0_last_pixel", {Pixel_x, Pixel_y}, {12'd639, 12'd479});
      if (cyc == 10) begin Mode_req = 1'b1; Mode_sel = 1'b1; end
      tick();
    end
    chk("m0_hsync_low", hs_low, 50400);
    chk("m0_hsync_place", hs_bad, 0);
    chk("m0_vsync_low", vs_low, 1600);
    chk("m0_vsync_place", vs_bad, 0);
    chk("m0_line_starts", ls_cnt, 525);
    chk("m0_line_place", ls_bad, 0);
    chk("m0_frame_starts", fs_cnt, 1);
    chk("m0_video_cnt", vid_cnt, 307200);
    chk("m0_first_video", first_vid, 28144);
    chk("m0_no_early_ack", ack_cnt, 0);

    run_m1(98, 1'b1, 0);
    run_m1(98, 1'b0, 1);
    run_m1(98, 1'b1, 2);
    run_m1(48, 1'b1, 3);

    Rst = 1'b1;
    tick();
    chk("reset_mid_1", obs(), rst_v);
    tick();
    chk("reset_mid_2", obs(), rst_v);
    Rst = 1'b0;
    tick();
    for (int k = 0; k < 1600; k++) begin
      chk("m0_after_reset", obs(), pack(0, (k % 800) >= 96, 0, 0, (k % 800) == 0, k == 0, 0, 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
